// File: rtl/moving_average_n_if.sv
// moving_average_n_if: sample stream in, smoothed stream out, with window clear and full flag
interface moving_average_n_if #(
    parameter int DATA_WD = 16
);
    logic                      i_valid;
    logic signed [DATA_WD-1:0] i_data;
    logic                      i_clear;
    logic                      o_valid;
    logic signed [DATA_WD-1:0] o_data;
    logic                      o_full;
    modport master (output i_valid, i_data, i_clear, input o_valid, o_data, o_full);
    modport slave  (input i_valid, i_data, i_clear, output o_valid, o_data, o_full);
endinterface

// File: rtl/moving_average_n.sv
// moving_average_n: N-tap boxcar average using a circular buffer and a running accumulator
module moving_average_n #(
    parameter int DATA_WD   = 16,
    parameter int LOG2_TAPS = 3,
    parameter int ROUND     = 0
) (
    input logic               i_clk,
    input logic               i_rst,
    moving_average_n_if.slave bus
);
    localparam int TAPS = 1 << LOG2_TAPS;
    localparam int AW = DATA_WD + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] FULL = TAPS[LOG2_TAPS:0];
    localparam logic signed [AW-1:0] RND = (ROUND != 0) ? AW'(TAPS / 2) : '0;

    logic signed [DATA_WD-1:0] taps_q [TAPS];
    logic [LOG2_TAPS-1:0]      wptr;
    logic [LOG2_TAPS:0]        fill;
    logic signed [AW-1:0]      acc;
    logic signed [AW-1:0]      acc_next;
    logic signed [AW-1:0]      rnd;

    assign bus.o_full = fill == FULL;

    // new sum replaces the oldest sample with the incoming one; the rounding bias is zero when truncating
    always_comb begin
        acc_next = acc + $signed({{LOG2_TAPS{bus.i_data[DATA_WD-1]}}, bus.i_data})
                       - $signed({{LOG2_TAPS{taps_q[wptr][DATA_WD-1]}}, taps_q[wptr]});
        rnd = acc_next + RND;
    end

    // reset and clear flush the whole window; otherwise an accepted sample advances it by one slot
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_clear) begin
            for (int i = 0; i < TAPS; i++) taps_q[i] <= '0;
            wptr        <= '0;
            fill        <= '0;
            acc         <= '0;
            bus.o_valid <= 1'b0;
            bus.o_data  <= '0;
        end else begin
            bus.o_valid <= bus.i_valid;
            if (bus.i_valid) begin
                taps_q[wptr] <= bus.i_data;
                wptr         <= wptr + 1'b1;
                fill         <= (fill == FULL) ? fill : fill + 1'b1;
                acc          <= acc_next;
                bus.o_data   <= DATA_WD'(rnd >>> LOG2_TAPS);
            end
        end
    end
endmodule

// File: tb/tb_moving_average_n.sv
// tb_moving_average_n: truncating and rounding filters fed the same directed stream, checked by a scoreboard
module tb_moving_average_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;
    logic clear = 1'b0;
    logic signed [15:0] data = '0;
    int errors = 0;
    int checks = 0;
    logic [16:0] q0 [$];
    logic [16:0] q1 [$];
    logic signed [15:0] last0 = '0;
    logic signed [15:0] last1 = '0;

    always #5 clk = ~clk;

    moving_average_n_if #(.DATA_WD(16)) if0 ();
    moving_average_n_if #(.DATA_WD(16)) if1 ();
    assign if0.i_valid = valid;
    assign if0.i_data  = data;
    assign if0.i_clear = clear;
    assign if1.i_valid = valid;
    assign if1.i_data  = data;
    assign if1.i_clear = clear;

    moving_average_n #(.DATA_WD(16), .LOG2_TAPS(3), .ROUND(0)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0.slave));
    moving_average_n #(.DATA_WD(16), .LOG2_TAPS(3), .ROUND(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor for the truncating filter
    always @(negedge clk) begin
        if (if0.o_valid) begin
            if (q0.size() == 0) chk("r0 unexpected o_valid", 1, 0);
            else begin
                logic [16:0] e;
                e = q0.pop_front();
                chk("r0 o_data", int'(if0.o_data), int'($signed(e[15:0])));
                chk("r0 o_full", int'(if0.o_full), int'(e[16]));
            end
        end
    end

    // monitor for the rounding filter
    always @(negedge clk) begin
        if (if1.o_valid) begin
            if (q1.size() == 0) chk("r1 unexpected o_valid", 1, 0);
            else begin
                logic [16:0] e;
                e = q1.pop_front();
                chk("r1 o_data", int'(if1.o_data), int'($signed(e[15:0])));
                chk("r1 o_full", int'(if1.o_full), int'(e[16]));
            end
        end
    end

    task automatic send(input logic signed [15:0] d, input logic signed [15:0] e0,
                        input logic signed [15:0] e1, input logic f);
        valid = 1'b1;
        data  = d;
        q0.push_back({f, e0});
        q1.push_back({f, e1});
        last0 = e0;
        last1 = e1;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("gap o_valid", int'(if0.o_valid | if1.o_valid), 0);
            chk("gap r0 hold", int'(if0.o_data), int'(last0));
            chk("gap r1 hold", int'(if1.o_data), int'(last1));
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, " o_valid"}, int'(if0.o_valid | if1.o_valid), 0);
        chk({name, " o_data"}, int'(if0.o_data | if1.o_data), 0);
        chk({name, " o_full"}, int'(if0.o_full | if1.o_full), 0);
    endtask

    task automatic do_clear();
        valid = 1'b1;
        clear = 1'b1;
        data  = 16'sd5000;
        @(posedge clk);
        #1;
        valid = 1'b0;
        clear = 1'b0;
        check_zero("clear");
        last0 = '0;
        last1 = '0;
    endtask

    task automatic do_reset(input int n);
        rst   = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            data = 16'($urandom);
            @(posedge clk);
            #1 check_zero("reset");
        end
        rst   = 1'b0;
        valid = 1'b0;
        last0 = '0;
        last1 = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [15:0] s0 [8];
        logic signed [15:0] s1 [8];
        do_reset(4);
        s0 = '{12, 25, 37, 50, 62, 75, 87, 100};
        s1 = '{13, 25, 38, 50, 63, 75, 88, 100};
        for (int i = 0; i < 8; i++) send(16'sd100, s0[i], s1[i], i == 7);
        send(16'sd100, 16'sd100, 16'sd100, 1'b1);
        send(16'sd100, 16'sd100, 16'sd100, 1'b1);
        do_clear();
        send(16'sd80, 16'sd10, 16'sd10, 1'b0);
        do_clear();
        send(16'sd800, 16'sd100, 16'sd100, 1'b0);
        for (int i = 1; i < 8; i++) send(16'sd0, 16'sd100, 16'sd100, i == 7);
        send(16'sd0, 16'sd0, 16'sd0, 1'b1);
        do_clear();
        for (int i = 1; i <= 8; i++) send(-16'sd32768, 16'(-4096 * i), 16'(-4096 * i), i == 8);
        do_clear();
        s0 = '{4095, 8191, 12287, 16383, 20479, 24575, 28671, 32767};
        s1 = '{4096, 8192, 12288, 16384, 20479, 24575, 28671, 32767};
        for (int i = 0; i < 8; i++) send(16'sd32767, s0[i], s1[i], i == 7);
        do_clear();
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) send(16'sd32767, (i < 8) ? 16'sd4095 : 16'sd0, (i < 8) ? 16'sd4096 : 16'sd0, i >= 7);
            else send(-16'sd32767, 16'sd0, 16'sd0, i >= 7);
        end
        do_clear();
        send(-16'sd1, -16'sd1, 16'sd0, 1'b0);
        do_clear();
        send(16'sd10, 16'sd1, 16'sd1, 1'b0);
        idle(2);
        send(16'sd20, 16'sd3, 16'sd4, 1'b0);
        send(-16'sd7, 16'sd2, 16'sd3, 1'b0);
        idle(3);
        send(16'sd3, 16'sd3, 16'sd3, 1'b0);
        idle(1);
        send(16'sd50, 16'sd9, 16'sd10, 1'b0);
        do_reset(3);
        send(16'sd100, 16'sd12, 16'sd13, 1'b0);
        idle(2);
        chk("r0 queue drained", q0.size(), 0);
        chk("r1 queue drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
